// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data memory responder.
// Holds the FSM state encoding, wait-state counter width and byte-lane geometry.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam int DMEM_WS_W   = 4;
   localparam int DMEM_LANES  = 4;
   localparam int DMEM_LANE_W = 8;
   localparam int DMEM_DATA_W = DMEM_LANES * DMEM_LANE_W;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU M-stage data port bundle between the pipeline (master) and the memory responder (slave).
// Handshake: the master raises mem_write_M or mem_or_alu_M and holds every request field stable until it samples data_mem_ack_M high for one cycle; dropping the request before then cancels it.
interface data_mem_responder_if;
   import dmem_pkg::*;

   logic                   mem_write_M;
   logic                   mem_or_alu_M;
   logic [DMEM_LANES-1:0]  byte_repeat_en_M;
   logic [DMEM_DATA_W-1:0] alu_out_M;
   logic [DMEM_DATA_W-1:0] write_data_M;
   logic [DMEM_DATA_W-1:0] read_data_M;
   logic                   data_mem_ack_M;
   logic                   bus_err_M;

   modport master (
      output mem_write_M, mem_or_alu_M, byte_repeat_en_M, alu_out_M, write_data_M,
      input  read_data_M, data_mem_ack_M, bus_err_M
   );

   modport slave (
      input  mem_write_M, mem_or_alu_M, byte_repeat_en_M, alu_out_M, write_data_M,
      output read_data_M, data_mem_ack_M, bus_err_M
   );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
// Read-before-write: on an enabled edge rdata captures the word as it was before the write.
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [DMEM_LANES-1:0]  we,
   input  logic [DMEM_DATA_W-1:0] wdata,
   output logic [DMEM_DATA_W-1:0] rdata
);

   logic [DMEM_DATA_W-1:0] mem [2**ADDR_WIDTH];

   // Storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < DMEM_LANES; i++) begin
            if (we[i]) begin
               mem[addr][i*DMEM_LANE_W +: DMEM_LANE_W] <= wdata[i*DMEM_LANE_W +: DMEM_LANE_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU M-stage data port: wait-state FSM, range check,
// and response registers around a byte-enabled word RAM; one-cycle ack per access.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic          clk,
   input  logic          reset,
   data_mem_responder_if.slave bus,
   output dmem_state_t   state_dbg
);

   localparam logic [DMEM_WS_W-1:0] WS_INIT = DMEM_WS_W'(WAIT_STATES);

   dmem_state_t            state_q, state_d;
   logic [DMEM_WS_W-1:0]   cnt_q, cnt_d;
   logic                   req;
   logic                   in_range;
   logic                   access;
   logic                   oor_q;
   logic [ADDR_WIDTH-1:0]  word_idx;
   logic [DMEM_LANES-1:0]  ram_we;
   logic [DMEM_DATA_W-1:0] ram_rdata;

   assign req      = bus.mem_write_M | bus.mem_or_alu_M;
   assign word_idx = bus.alu_out_M[ADDR_WIDTH+1:2];
   assign in_range = (bus.alu_out_M >> (ADDR_WIDTH + 2)) == '0;
   assign ram_we   = bus.mem_write_M ? bus.byte_repeat_en_M : '0;

   // The counter holds the number of WAIT cycles left including the current one,
   // so the access edge is the one on which it would reach zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  access  = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = WS_INIT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q <= 1) begin
               cnt_d   = '0;
               access  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (access) begin
            oor_q <= !in_range;
         end
      end
   end

   // Gating with reset keeps a held request from writing while reset is low.
   dmem_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (reset),
      .en    (access & in_range & reset),
      .addr  (word_idx),
      .we    (ram_we),
      .wdata (bus.write_data_M),
      .rdata (ram_rdata)
   );

   assign bus.read_data_M    = oor_q ? '0 : ram_rdata;
   assign bus.data_mem_ack_M = (state_q == RESP);
   assign bus.bus_err_M      = (state_q == RESP) & oor_q;
   assign state_dbg          = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 1 and 3 wait states) driven by directed
// steps and random traffic, checked against a byte-level memory model.
module tb_data_mem_responder;
   import dmem_pkg::*;

   logic clk;
   logic reset;

   logic        mw  [3];
   logic        ml  [3];
   logic [3:0]  be_s[3];
   logic [31:0] ae  [3];
   logic [31:0] wd  [3];
   logic [31:0] rd  [3];
   logic        ack [3];
   logic        err [3];
   dmem_state_t st_dbg[3];

   int ws_of[3] = '{0, 1, 3};
   int tests = 0;
   int fails = 0;

   logic [31:0] model_mem [3][1024];
   bit          known     [3][1024];

   data_mem_responder_if ifs[3] ();

   for (genvar g = 0; g < 3; g++) begin : g_map
      assign ifs[g].mem_write_M      = mw[g];
      assign ifs[g].mem_or_alu_M     = ml[g];
      assign ifs[g].byte_repeat_en_M = be_s[g];
      assign ifs[g].alu_out_M        = ae[g];
      assign ifs[g].write_data_M     = wd[g];
      assign rd[g]  = ifs[g].read_data_M;
      assign ack[g] = ifs[g].data_mem_ack_M;
      assign err[g] = ifs[g].bus_err_M;
   end

   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset(reset), .bus(ifs[0]), .state_dbg(st_dbg[0]));
   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .reset(reset), .bus(ifs[1]), .state_dbg(st_dbg[1]));
   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset(reset), .bus(ifs[2]), .state_dbg(st_dbg[2]));

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Driver: present one request in an IDLE cycle and hold it until the ack (bounded).
   task automatic access(input int k, input bit st, input bit both, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         output logic [31:0] rdata, output logic e, output int lat);
      @(negedge clk);
      mw[k] = st; ml[k] = !st || both; ae[k] = addr; wd[k] = data; be_s[k] = be;
      lat = -1; rdata = '0; e = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (ack[k]) begin
            lat = n; rdata = rd[k]; e = err[k];
            break;
         end
      end
      mw[k] = 1'b0; ml[k] = 1'b0;
   endtask

   // Scoreboard step: expected response from the memory model, then update the model.
   task automatic xact(input int k, input bit st, input bit both, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, output logic [31:0] got);
      logic [31:0] exp_rd;
      logic        exp_err, e;
      bit          chk_rd;
      int          idx, lat;
      exp_err = (addr >= 32'h1000);
      idx     = int'(addr[11:2]);
      chk_rd  = 1'b1;
      if (exp_err) exp_rd = '0;
      else begin
         exp_rd = model_mem[k][idx];
         chk_rd = known[k][idx];
      end
      access(k, st, both, addr, data, be, got, e, lat);
      chk($sformatf("lat k%0d a=%h", k, addr), 32'(lat), 32'(ws_of[k] + 1));
      chk($sformatf("err k%0d a=%h", k, addr), {31'b0, e}, {31'b0, exp_err});
      if (chk_rd) chk($sformatf("rd k%0d a=%h st=%0d", k, addr, st), got, exp_rd);
      if (st && !exp_err) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) model_mem[k][idx][8*b +: 8] = data[8*b +: 8];
         if (be == 4'hF) known[k][idx] = 1'b1;
      end
   endtask

   initial begin
      logic [31:0] got, addr, data;
      bit st, both;
      int seen;

      for (int k = 0; k < 3; k++) begin
         mw[k] = 0; ml[k] = 0; be_s[k] = '0; ae[k] = '0; wd[k] = '0;
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst ack k%0d", k), {31'b0, ack[k]}, 32'd0);
         chk($sformatf("rst err k%0d", k), {31'b0, err[k]}, 32'd0);
         chk($sformatf("rst rd k%0d", k), rd[k], 32'd0);
         chk($sformatf("rst state k%0d", k), 32'(st_dbg[k]), 32'(IDLE));
      end
      reset = 1'b1;

      // Full-word store then load, one wait state
      xact(1, 1, 0, 32'h40, 32'hDEADBEEF, 4'hF, got);
      xact(1, 0, 0, 32'h40, 32'h0, 4'h0, got);
      chk("load after store", got, 32'hDEADBEEF);

      // Single-lane store shows the pre-write word, then the merged word
      xact(1, 1, 0, 32'h40, 32'h55555555, 4'b0100, got);
      chk("byte store pre-write", got, 32'hDEADBEEF);
      xact(1, 0, 0, 32'h40, 32'h0, 4'h0, got);
      chk("byte store merged", got, 32'hDE55BEEF);

      // Out-of-range load and store; word 0 must not alias
      xact(1, 1, 0, 32'h0, 32'h0BADF00D, 4'hF, got);
      xact(1, 0, 0, 32'h1000, 32'h0, 4'h0, got);
      chk("oor load data", got, 32'h0);
      xact(1, 1, 0, 32'h1000, 32'hFFFFFFFF, 4'hF, got);
      xact(1, 0, 0, 32'h0, 32'h0, 4'h0, got);
      chk("oor store no alias", got, 32'h0BADF00D);

      // Empty byte enables, and both request bits high meaning store
      xact(1, 1, 0, 32'h40, 32'h0, 4'h0, got);
      xact(1, 0, 0, 32'h40, 32'h0, 4'h0, got);
      chk("be0000 no write", got, 32'hDE55BEEF);
      xact(1, 1, 1, 32'h44, 32'h11223344, 4'hF, got);
      xact(1, 0, 0, 32'h44, 32'h0, 4'h0, got);
      chk("both high is store", got, 32'h11223344);

      // Flush in WAIT with three wait states
      xact(2, 1, 0, 32'h80, 32'hCAFEF00D, 4'hF, got);
      @(negedge clk);
      mw[2] = 1; ml[2] = 0; ae[2] = 32'h80; wd[2] = 32'h01010101; be_s[2] = 4'hF;
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (ack[2]) seen++;
      end
      mw[2] = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack[2]) seen++;
      end
      chk("flush no ack", 32'(seen), 32'd0);
      xact(2, 0, 0, 32'h80, 32'h0, 4'h0, got);
      chk("flush no write", got, 32'hCAFEF00D);

      // Zero wait states with the load held continuously
      xact(0, 1, 0, 32'h10, 32'hA5A50F0F, 4'hF, got);
      @(negedge clk);
      ml[0] = 1; ae[0] = 32'h10;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         chk($sformatf("held ack n%0d", n), {31'b0, ack[0]}, 32'(n % 2));
         if (ack[0]) chk($sformatf("held rd n%0d", n), rd[0], 32'hA5A50F0F);
      end
      ml[0] = 0;

      // Reset in the middle of a store's WAIT
      xact(2, 1, 0, 32'hC0, 32'h12345678, 4'hF, got);
      xact(2, 0, 0, 32'hC0, 32'h0, 4'h0, got);
      @(negedge clk);
      mw[2] = 1; ae[2] = 32'hC0; wd[2] = 32'h87654321; be_s[2] = 4'hF;
      repeat (2) @(negedge clk);
      chk("pre-reset no ack", {31'b0, ack[2]}, 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("midrst ack", {31'b0, ack[2]}, 32'd0);
      chk("midrst err", {31'b0, err[2]}, 32'd0);
      chk("midrst rd", rd[2], 32'd0);
      chk("midrst state", 32'(st_dbg[2]), 32'(IDLE));
      mw[2] = 0;
      @(negedge clk);
      reset = 1'b1;
      xact(2, 0, 0, 32'hC0, 32'h0, 4'h0, got);
      chk("midrst no write", got, 32'h12345678);

      // Random traffic on every instance
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++)
            xact(k, 1, 0, 32'h200 + 32'(i * 4), $urandom, 4'hF, got);
         for (int i = 0; i < 25; i++) begin
            st   = 1'($urandom_range(0, 1));
            both = st && ($urandom_range(0, 1) == 1);
            data = $urandom;
            if ($urandom_range(0, 7) == 0)
               addr = (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 4095));
            else
               addr = 32'h200 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            xact(k, st, both, addr, data, 4'($urandom_range(0, 15)), got);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
